// File: rtl/in_handshake_ctrl.sv
// rtl/in_handshake_ctrl.sv - IN-instruction responder: key sync/debounce, switch capture, CPU halt handshake (optional INPUT_TIMEOUT_EN)
module in_handshake_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic        clock,
    input  logic        reseta,
    input  logic        req,
    input  logic        botao,
    input  logic [17:0] switch,
    output logic        halt,
    output logic [17:0] dado,
    output logic        valido,
    output logic        expirou,
    output logic        pressionado
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ESPERA = 2'd1,
        SOLTA  = 2'd2
    } state_t;

    // Both counters compare against N-1, so a zero-length window is meaningless.
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("in_handshake_ctrl: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_t          state, state_n;
    logic            sync1, sync2;
    logic [DB_W-1:0] db_cnt;
    logic            key_lvl, differ, toggle;
    logic            press_evt, release_evt;
    logic            pendente, pend_n;
    logic            halt_n, valido_n, expirou_n;
    logic [17:0]     dado_n;
    logic            timeout_hit;

    // Two-flop synchronizer; resets to 1 so a released key is assumed.
    always_ff @(posedge clock) begin
        if (reseta) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= botao;
            sync2 <= sync1;
        end
    end

    // Key is active-low on the pin; internally 1 means pressed.
    assign key_lvl     = ~sync2;
    assign differ      = (key_lvl != pressionado);
    assign toggle      = differ && (db_cnt == DB_LAST);
    assign press_evt   = toggle && !pressionado;
    assign release_evt = toggle && pressionado;

    // Debounce: debounced level follows the synchronized level only after it has been stable long enough.
    always_ff @(posedge clock) begin
        if (reseta) begin
            db_cnt      <= '0;
            pressionado <= 1'b0;
        end else if (!differ) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt      <= '0;
            pressionado <= ~pressionado;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

`ifdef INPUT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] wait_cnt;

    // Wait counter is held at zero outside ESPERA so every entry starts a fresh window.
    always_ff @(posedge clock) begin
        if (reseta || state != ESPERA) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state == ESPERA) && (wait_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Handshake next-state and registered-output values.
    always_comb begin
        state_n   = state;
        halt_n    = halt;
        pend_n    = pendente;
        dado_n    = dado;
        valido_n  = 1'b0;
        expirou_n = 1'b0;
        case (state)
            IDLE: begin
                halt_n = 1'b0;
                if (req) begin
                    state_n = ESPERA;
                    halt_n  = 1'b1;
                end
            end
            ESPERA: begin
                halt_n = 1'b1;
                if (press_evt) begin
                    dado_n   = switch;
                    valido_n = 1'b1;
                    halt_n   = 1'b0;
                    state_n  = SOLTA;
                end else if (timeout_hit) begin
                    dado_n    = switch;
                    valido_n  = 1'b1;
                    expirou_n = 1'b1;
                    halt_n    = 1'b0;
                    state_n   = IDLE;
                end
            end
            SOLTA: begin
                halt_n = pendente;
                if (release_evt) begin
                    if (pendente || req) begin
                        state_n = ESPERA;
                        pend_n  = 1'b0;
                        halt_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        halt_n  = 1'b0;
                    end
                end else if (req) begin
                    pend_n = 1'b1;
                    halt_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                halt_n  = 1'b0;
                pend_n  = 1'b0;
            end
        endcase
    end

    // Handshake state and output registers; reset wins over any event.
    always_ff @(posedge clock) begin
        if (reseta) begin
            state    <= IDLE;
            halt     <= 1'b0;
            pendente <= 1'b0;
            dado     <= '0;
            valido   <= 1'b0;
            expirou  <= 1'b0;
        end else begin
            state    <= state_n;
            halt     <= halt_n;
            pendente <= pend_n;
            dado     <= dado_n;
            valido   <= valido_n;
            expirou  <= expirou_n;
        end
    end

endmodule

// File: tb/tb_in_handshake_ctrl.sv
// tb/tb_in_handshake_ctrl.sv - table-driven and sequence checks for in_handshake_ctrl
module tb_in_handshake_ctrl;

    logic        clock = 1'b0;
    logic        reseta;
    logic        req;
    logic        botao;
    logic [17:0] switch;
    logic        halt;
    logic [17:0] dado;
    logic        valido;
    logic        expirou;
    logic        pressionado;

    in_handshake_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock      (clock),
        .reseta     (reseta),
        .req        (req),
        .botao      (botao),
        .switch     (switch),
        .halt       (halt),
        .dado       (dado),
        .valido     (valido),
        .expirou    (expirou),
        .pressionado(pressionado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        rq;
        logic        btn;
        logic [17:0] sw;
        logic        e_halt;
        logic        e_val;
        logic        e_press;
        logic [17:0] e_dado;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vcount   = 0;

    localparam logic [17:0] SW_A = 18'h2A5A5;
    localparam logic [17:0] SW_B = 18'h15A5A;

    task automatic add(input logic r, input logic q, input logic b, input logic [17:0] s,
                       input logic h, input logic v, input logic p, input logic [17:0] d);
        vec_t e;
        e.rst = r; e.rq = q; e.btn = b; e.sw = s;
        e.e_halt = h; e.e_val = v; e.e_press = p; e.e_dado = d;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (valido === 1'b1) vcount++;
    endtask

    task automatic wait_valido(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (valido !== 1'b1 && n < max);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v0;
        int halt_low;
        int exp_seen;

        reseta = 1'b1;
        req    = 1'b0;
        botao  = 1'b1;
        switch = '0;

        // Scenario 1: request, stable press, capture, release back to IDLE.
        add(1, 0, 1, 18'h0, 0, 0, 0, 18'h0);
        add(0, 1, 1, SW_A,  1, 0, 0, 18'h0);
        for (int k = 0; k < 5; k++) add(0, 0, 0, SW_A, 1, 0, 0, 18'h0);
        add(0, 0, 0, SW_A, 0, 1, 1, SW_A);
        for (int k = 0; k < 4; k++) add(0, 0, 0, SW_A, 0, 0, 1, SW_A);
        for (int k = 0; k < 5; k++) add(0, 0, 1, SW_A, 0, 0, 1, SW_A);
        add(0, 0, 1, SW_A, 0, 0, 0, SW_A);
        // Scenario 2: request, then a bouncing key settling low.
        add(0, 1, 1, SW_B, 1, 0, 0, SW_A);
        add(0, 0, 1, SW_B, 1, 0, 0, SW_A);
        add(0, 0, 0, SW_B, 1, 0, 0, SW_A);
        add(0, 0, 1, SW_B, 1, 0, 0, SW_A);
        for (int k = 0; k < 5; k++) add(0, 0, 0, SW_B, 1, 0, 0, SW_A);
        add(0, 0, 0, SW_B, 0, 1, 1, SW_B);
        for (int k = 0; k < 2; k++) add(0, 0, 0, SW_B, 0, 0, 1, SW_B);
        for (int k = 0; k < 5; k++) add(0, 0, 1, SW_B, 0, 0, 1, SW_B);
        add(0, 0, 1, SW_B, 0, 0, 0, SW_B);

        for (int i = 0; i < tbl.size(); i++) begin
            reseta = tbl[i].rst;
            req    = tbl[i].rq;
            botao  = tbl[i].btn;
            switch = tbl[i].sw;
            tick();
            check($sformatf("vec%0d halt", i),        32'(halt),        32'(tbl[i].e_halt));
            check($sformatf("vec%0d valido", i),      32'(valido),      32'(tbl[i].e_val));
            check($sformatf("vec%0d pressionado", i), 32'(pressionado), 32'(tbl[i].e_press));
            check($sformatf("vec%0d dado", i),        32'(dado),        32'(tbl[i].e_dado));
            check($sformatf("vec%0d expirou", i),     32'(expirou),     32'(1'b0));
        end
        req   = 1'b0;
        check("scenario2 single valido", 32'(vcount), 32'd2);

        // Scenario 3: press in IDLE ignored; key held at request needs a fresh press.
        v0 = vcount;
        botao = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("idle press level", 32'(pressionado), 32'd1);
        check("idle press no halt", 32'(halt), 32'd0);
        check("idle press no valido", 32'(vcount), 32'(v0));
        req = 1'b1; tick(); req = 1'b0;
        check("held req halt", 32'(halt), 32'd1);
        botao = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        check("held release level", 32'(pressionado), 32'd0);
        check("held release halt", 32'(halt), 32'd1);
        check("held no capture", 32'(vcount), 32'(v0));
        switch = 18'h0ABCD;
        botao  = 1'b0;
        wait_valido(12, n);
        check("repress latency", 32'(n), 32'd6);
        check("repress dado", 32'(dado), 32'h0ABCD);
        check("repress halt", 32'(halt), 32'd0);

        // Scenario 4: request during SOLTA queues one more wait.
        tick();
        switch = 18'h00003;
        req = 1'b1; tick(); req = 1'b0;
        check("solta req halt", 32'(halt), 32'd1);
        req = 1'b1; tick(); req = 1'b0;
        check("solta second req halt", 32'(halt), 32'd1);
        v0 = vcount;
        botao = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        check("pend release level", 32'(pressionado), 32'd0);
        check("pend espera halt", 32'(halt), 32'd1);
        check("pend no capture", 32'(vcount), 32'(v0));
        botao = 1'b0;
        wait_valido(12, n);
        check("pend latency", 32'(n), 32'd6);
        check("pend dado", 32'(dado), 32'h00003);
        check("pend expirou", 32'(expirou), 32'd0);
        botao = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        check("pend back idle halt", 32'(halt), 32'd0);

        // Scenario 5: reset in ESPERA.
        req = 1'b1; tick(); req = 1'b0;
        check("pre-reset halt", 32'(halt), 32'd1);
        reseta = 1'b1; tick(); reseta = 1'b0;
        check("reset halt", 32'(halt), 32'd0);
        check("reset dado", 32'(dado), 32'd0);
        check("reset valido", 32'(valido), 32'd0);
        v0 = vcount;
        botao = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("post-reset press level", 32'(pressionado), 32'd1);
        check("post-reset no valido", 32'(vcount), 32'(v0));
        check("post-reset halt", 32'(halt), 32'd0);
        botao = 1'b1;
        for (int k = 0; k < 8; k++) tick();

        // Scenario 6: no press while waiting.
        switch = 18'h1FFFF;
        req = 1'b1; tick(); req = 1'b0;
        check("wait halt", 32'(halt), 32'd1);
`ifdef INPUT_TIMEOUT_EN
        wait_valido(30, n);
        check("timeout latency", 32'(n), 32'd20);
        check("timeout expirou", 32'(expirou), 32'd1);
        check("timeout dado", 32'(dado), 32'h1FFFF);
        check("timeout halt", 32'(halt), 32'd0);
        tick();
        check("timeout pulse valido", 32'(valido), 32'd0);
        check("timeout pulse expirou", 32'(expirou), 32'd0);
        switch = 18'h00055;
        req = 1'b1; tick(); req = 1'b0;
        botao = 1'b0;
        wait_valido(12, n);
        check("after timeout idle latency", 32'(n), 32'd6);
        check("after timeout dado", 32'(dado), 32'h00055);
        check("after timeout expirou", 32'(expirou), 32'd0);
        botao = 1'b1;
        for (int k = 0; k < 8; k++) tick();
`else
        v0 = vcount;
        halt_low = 0;
        exp_seen = 0;
        for (int k = 0; k < 105; k++) begin
            tick();
            if (halt !== 1'b1) halt_low++;
            if (expirou !== 1'b0) exp_seen++;
        end
        check("no timeout halt held", 32'(halt_low), 32'd0);
        check("no timeout expirou", 32'(exp_seen), 32'd0);
        check("no timeout valido", 32'(vcount), 32'(v0));
        reseta = 1'b1; tick(); reseta = 1'b0;
        check("final reset halt", 32'(halt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
